// File: rtl/car_sensor_emulator.sv
// Four-phase photo-sensor stimulus source for the parking-lot occupancy counter.
// Optional occupancy tracker enabled by defining CAR_SENSOR_EMU_COUNT_EN.
module car_sensor_emulator #(
  parameter int DWELL_W   = 8,
  parameter int COUNT_W   = 5,
  parameter int MAX_COUNT = 25
) (
  input  logic               CLOCK_50,
  input  logic               reset_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_dir,
  input  logic [DWELL_W-1:0] cmd_dwell,
  input  logic               cmd_abort,
  output logic               outer,
  output logic               inner,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic [COUNT_W-1:0] car_count
);

  typedef enum logic [2:0] {
    IDLE,
    P1,
    P2,
    P3,
    P4
  } state_t;

  localparam logic [DWELL_W-1:0] ONE = DWELL_W'(1);

  state_t             state;
  state_t             nxt;
  logic               dir;
  logic [DWELL_W-1:0] dwell_m1;
  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] dwell_in_m1;
  logic               phase_last;
  logic               complete;

  // Counter holds remaining cycles minus one, so D = 2^W-1 never wraps.
  assign dwell_in_m1 = (cmd_dwell == '0) ? '0 : cmd_dwell - ONE;
  assign phase_last  = (cnt == '0);
  assign cmd_ready   = (state == IDLE);
  assign complete    = (state == P4) && phase_last && !cmd_abort;

  function automatic logic [1:0] levels(state_t s, logic d);
    logic [1:0] lv;
    lv = 2'b00;
    unique case (s)
      P1:      lv = d ? 2'b01 : 2'b10;
      P2:      lv = 2'b11;
      P3:      lv = d ? 2'b10 : 2'b01;
      default: lv = 2'b00;
    endcase
    return lv;
  endfunction

  always_comb begin
    nxt = IDLE;
    unique case (state)
      P1:      nxt = P2;
      P2:      nxt = P3;
      P3:      nxt = P4;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      dir      <= 1'b0;
      dwell_m1 <= '0;
      cnt      <= '0;
      outer    <= 1'b0;
      inner    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      aborted  <= 1'b0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      if (state == IDLE) begin
        if (cmd_valid) begin
          state            <= P1;
          dir              <= cmd_dir;
          dwell_m1         <= dwell_in_m1;
          cnt              <= dwell_in_m1;
          {outer, inner}   <= levels(P1, cmd_dir);
          busy             <= 1'b1;
        end
      end else if (cmd_abort) begin
        state          <= IDLE;
        {outer, inner} <= 2'b00;
        busy           <= 1'b0;
        aborted        <= 1'b1;
      end else if (!phase_last) begin
        cnt <= cnt - ONE;
      end else begin
        state          <= nxt;
        cnt            <= dwell_m1;
        {outer, inner} <= levels(nxt, dir);
        if (state == P4) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

`ifdef CAR_SENSOR_EMU_COUNT_EN
  localparam logic [COUNT_W-1:0] CNT_MAX = COUNT_W'(MAX_COUNT);
  localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      car_count <= '0;
    end else if (complete) begin
      if (!dir) begin
        if (car_count < CNT_MAX) car_count <= car_count + CNT_ONE;
      end else if (car_count != '0) begin
        car_count <= car_count - CNT_ONE;
      end
    end
  end
`else
  assign car_count = '0;
`endif

endmodule

// File: tb/tb_car_sensor_emulator.sv
// Directed bench for car_sensor_emulator: vector table of car
// sequences plus hand-written abort and mid-sequence reset cases.
module tb_car_sensor_emulator;

  logic       CLOCK_50;
  logic       reset_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_dir;
  logic [7:0] cmd_dwell;
  logic       cmd_abort;
  logic       outer;
  logic       inner;
  logic       busy;
  logic       done;
  logic       aborted;
  logic [4:0] car_count;

  int checks = 0;
  int errors = 0;
  int model  = 0;

  typedef struct {
    bit dir;
    int dwell;
    int exp_count;
  } vec_t;

  vec_t vecs[8];

  car_sensor_emulator #(
    .DWELL_W(8),
    .COUNT_W(5),
    .MAX_COUNT(25)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset_n  (reset_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_dir  (cmd_dir),
    .cmd_dwell(cmd_dwell),
    .cmd_abort(cmd_abort),
    .outer    (outer),
    .inner    (inner),
    .busy     (busy),
    .done     (done),
    .aborted  (aborted),
    .car_count(car_count)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  function automatic int ec(input int m);
`ifdef CAR_SENSOR_EMU_COUNT_EN
    return m;
`else
    return 0;
`endif
  endfunction

  function automatic logic [1:0] lv(input bit d, input int p);
    logic [1:0] r;
    case (p)
      0:       r = d ? 2'b01 : 2'b10;
      1:       r = 2'b11;
      2:       r = d ? 2'b10 : 2'b01;
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // {outer,inner,busy,done,aborted,cmd_ready}
  function automatic logic [5:0] obs();
    return {outer, inner, busy, done, aborted, cmd_ready};
  endfunction

  task automatic run_cmd(input bit d, input int dw, input int expc,
                         input string tag);
    int dd;
    dd = (dw == 0) ? 1 : dw;
    chk({tag, ".ready"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_dir   = d;
    cmd_dwell = 8'(dw);
    for (int j = 0; j < 4 * dd; j++) begin
      @(posedge CLOCK_50); #1;
      if (j == 0) begin
        cmd_valid = 1'b0;
        cmd_dir   = ~d;
        cmd_dwell = 8'd7;
      end
      chk({tag, ".phase"}, 32'(obs()),
          32'({lv(d, j / dd), 4'b1000}));
    end
    @(posedge CLOCK_50); #1;
    chk({tag, ".done"}, 32'(obs()), 32'(6'b000101));
    chk({tag, ".count"}, 32'(car_count), 32'(ec(expc)));
  endtask

  initial begin
    vecs[0] = '{0, 1, 1};
    vecs[1] = '{1, 0, 0};
    vecs[2] = '{1, 1, 0};
    vecs[3] = '{0, 0, 1};
    vecs[4] = '{0, 3, 2};
    vecs[5] = '{0, 3, 3};
    vecs[6] = '{1, 3, 2};
    vecs[7] = '{0, 255, 3};

    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_dir   = 1'b0;
    cmd_dwell = 8'd0;
    cmd_abort = 1'b0;
    #3;
    chk("reset.outputs", 32'(obs()), 32'(6'b000001));
    chk("reset.count", 32'(car_count), 32'd0);
    @(posedge CLOCK_50); #1;
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_cmd(vecs[i].dir, vecs[i].dwell, vecs[i].exp_count,
              $sformatf("vec%0d", i));
    end
    model = 3;

    for (int i = 0; i < 30; i++) begin
      model = (model < 25) ? model + 1 : 25;
      run_cmd(1'b0, 1, model, "sat");
    end

    // Abort during P2 of an enter
    cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_dwell = 8'd2;
    @(posedge CLOCK_50); #1;
    cmd_valid = 1'b0;
    repeat (2) @(posedge CLOCK_50);
    #1;
    chk("abp2.in_p2", 32'(obs()), 32'(6'b111000));
    cmd_abort = 1'b1;
    @(posedge CLOCK_50); #1;
    cmd_abort = 1'b0;
    chk("abp2.abort", 32'(obs()), 32'(6'b000011));
    chk("abp2.count", 32'(car_count), 32'(ec(model)));
    for (int i = 0; i < 3; i++) begin
      @(posedge CLOCK_50); #1;
      chk("abp2.quiet", 32'(obs()), 32'(6'b000001));
    end

    // Abort on the final P4 cycle
    cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_dwell = 8'd2;
    @(posedge CLOCK_50); #1;
    cmd_valid = 1'b0;
    repeat (7) @(posedge CLOCK_50);
    #1;
    chk("abp4.last", 32'(obs()), 32'(6'b001000));
    cmd_abort = 1'b1;
    @(posedge CLOCK_50); #1;
    cmd_abort = 1'b0;
    chk("abp4.abort", 32'(obs()), 32'(6'b000011));
    chk("abp4.count", 32'(car_count), 32'(ec(model)));

    // Abort on the accept edge is ignored
    cmd_valid = 1'b1; cmd_abort = 1'b1; cmd_dir = 1'b1; cmd_dwell = 8'd1;
    @(posedge CLOCK_50); #1;
    cmd_valid = 1'b0; cmd_abort = 1'b0;
    chk("abacc.p1", 32'(obs()), 32'(6'b011000));
    repeat (3) @(posedge CLOCK_50);
    @(posedge CLOCK_50); #1;
    model = model - 1;
    chk("abacc.done", 32'(obs()), 32'(6'b000101));
    chk("abacc.count", 32'(car_count), 32'(ec(model)));

    // Reset mid-P3
    cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_dwell = 8'd3;
    @(posedge CLOCK_50); #1;
    cmd_valid = 1'b0;
    repeat (7) @(posedge CLOCK_50);
    #1;
    chk("rst.in_p3", 32'(obs()), 32'(6'b011000));
    reset_n = 1'b0;
    #1;
    chk("rst.async", 32'(obs()), 32'(6'b000001));
    chk("rst.count", 32'(car_count), 32'd0);
    @(posedge CLOCK_50); #1;
    reset_n = 1'b1;
    model = 1;
    run_cmd(1'b0, 1, model, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
